// File: rtl/fa_res_if.sv
// Detection-record channel between the fault campaign sequencer and its host.
// Valid/ready handshake; the payload is held stable while valid is high.
interface fa_res_if #(
  parameter int SW = 1
);
  logic          res_valid;
  logic          res_ready;
  logic [SW-1:0] res_site;
  logic          res_stuck;
  logic          res_detected;
  logic [2:0]    res_vector;

  modport master (
    output res_valid,
    output res_site,
    output res_stuck,
    output res_detected,
    output res_vector,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_site,
    input  res_stuck,
    input  res_detected,
    input  res_vector,
    output res_ready
  );
endinterface

// File: rtl/fa_fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer for the good/faulty full-adder pair.
// Self-check pass, then every (site, stuck) fault over all 8 input vectors.
module fa_fault_campaign_ctrl #(
  parameter int NUM_SITES = 4,
  parameter int SETTLE    = 2,
  parameter int DROP      = 1,
  localparam int SW = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1,
  localparam int CW = $clog2(2 * NUM_SITES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          A,
  output logic          B,
  output logic          Cin,
  output logic          fault_enable,
  output logic          stuck_val,
  output logic [SW-1:0] fault_site,
  input  logic          fault_sum,
  input  logic          fault_cout,
  fa_res_if.master      res,
  output logic [CW-1:0] detected_count,
  output logic          self_check_err
);

  localparam int CNTW = $clog2(SETTLE + 2);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SAMPLE,
    REPORT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      vec_q, vec_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            fen_q, fen_d;
  logic            stuck_q, stuck_d;
  logic [SW-1:0]   site_q, site_d;
  logic            det_q, det_d;
  logic [2:0]      rvec_q, rvec_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            scerr_q, scerr_d;

  logic hit;
  logic drop_en;
  logic fin;
  logic last_f;

  assign hit     = fault_sum | fault_cout;
  assign drop_en = (DROP != 0);
  assign fin     = (vec_q == 3'd7)
                 || (drop_en && fen_q && (det_q || hit));
  assign last_f  = stuck_q
                 && (site_q == SW'(NUM_SITES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fen_q   <= 1'b0;
      stuck_q <= 1'b0;
      site_q  <= '0;
      det_q   <= 1'b0;
      rvec_q  <= '0;
      dcnt_q  <= '0;
      scerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fen_q   <= fen_d;
      stuck_q <= stuck_d;
      site_q  <= site_d;
      det_q   <= det_d;
      rvec_q  <= rvec_d;
      dcnt_q  <= dcnt_d;
      scerr_q <= scerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fen_d   = fen_q;
    stuck_d = stuck_q;
    site_d  = site_q;
    det_d   = det_q;
    rvec_d  = rvec_q;
    dcnt_d  = dcnt_q;
    scerr_d = scerr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          vec_d   = '0;
          cnt_d   = CNTW'(SETTLE);
          fen_d   = 1'b0;
          stuck_d = 1'b0;
          site_d  = '0;
          det_d   = 1'b0;
          rvec_d  = '0;
          dcnt_d  = '0;
          scerr_d = 1'b0;
        end
      end
      APPLY: begin
        if (cnt_q <= CNTW'(1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      SAMPLE: begin
        if (!fen_q) begin
          if (hit) scerr_d = 1'b1;
        end else if (hit && !det_q) begin
          det_d  = 1'b1;
          rvec_d = vec_q;
        end
        if (!fin) begin
          state_d = APPLY;
          vec_d   = vec_q + 3'd1;
          cnt_d   = CNTW'(SETTLE);
        end else if (fen_q) begin
          state_d = REPORT;
        end else begin
          // self-check finished: load the first fault
          state_d = APPLY;
          fen_d   = 1'b1;
          stuck_d = 1'b0;
          site_d  = '0;
          vec_d   = '0;
          det_d   = 1'b0;
          rvec_d  = '0;
          cnt_d   = CNTW'(SETTLE);
        end
      end
      REPORT: begin
        if (res.res_ready) begin
          if (det_q) dcnt_d = dcnt_q + CW'(1);
          if (last_f) begin
            state_d = DONE;
            fen_d   = 1'b0;
          end else begin
            // one extra hold cycle absorbs the fault-switch transition
            state_d = APPLY;
            stuck_d = ~stuck_q;
            site_d  = stuck_q ? site_q + SW'(1) : site_q;
            vec_d   = '0;
            det_d   = 1'b0;
            rvec_d  = '0;
            cnt_d   = CNTW'(SETTLE + 1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == APPLY)
              || (state_q == SAMPLE)
              || (state_q == REPORT);
  assign done = (state_q == DONE);

  assign A   = vec_q[2];
  assign B   = vec_q[1];
  assign Cin = vec_q[0];

  assign fault_enable = fen_q;
  assign stuck_val    = stuck_q;
  assign fault_site   = site_q;

  assign res.res_valid    = (state_q == REPORT);
  assign res.res_site     = site_q;
  assign res.res_stuck    = stuck_q;
  assign res.res_detected = det_q;
  assign res.res_vector   = rvec_q;

  assign detected_count = dcnt_q;
  assign self_check_err = scerr_q;

endmodule

// File: tb/tb_fa_fault_campaign_ctrl.sv
// Bench for fa_fault_campaign_ctrl: behavioural full-adder fault model,
// hand table of expected records, randomized campaigns, reset and DROP=0 runs.
module tb_fa_fault_campaign_ctrl;

  localparam int NS  = 4;
  localparam int ST  = 2;
  localparam int DR  = 1;
  localparam int SW  = 2;
  localparam int CW  = 4;
  localparam int NF  = 2 * NS;
  localparam int LIM = 3000;
  localparam int ST2 = 1;
  localparam int SW2 = 1;
  localparam int CW2 = 2;

  typedef struct {
    int site;
    int stk;
    int det;
    int vec;
    int k;
  } rec_t;

  typedef struct {
    int idx;
    int site;
    int stk;
    int det;
    int vec;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic start2;
  logic ign;
  logic force_sc;

  logic          busy, done, A, B, Cin, fen, stk;
  logic [SW-1:0] fsite;
  logic          fsum, fcout;
  logic [CW-1:0] dcnt;
  logic          scerr;

  logic           busy2, done2, A2, B2, Cin2, fen2, stk2;
  logic [SW2-1:0] fsite2;
  logic           fsum2, fcout2;
  logic [CW2-1:0] dcnt2;
  logic           scerr2;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t exp_q[$];
  rec_t got_q[$];
  tv_t  tbl[NF];

  always #5 clk = ~clk;

  fa_res_if #(.SW(SW))  rif ();
  fa_res_if #(.SW(SW2)) rif2 ();

  fa_fault_campaign_ctrl #(
    .NUM_SITES(NS), .SETTLE(ST), .DROP(DR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .A(A), .B(B), .Cin(Cin),
    .fault_enable(fen), .stuck_val(stk), .fault_site(fsite),
    .fault_sum(fsum), .fault_cout(fcout),
    .res(rif),
    .detected_count(dcnt), .self_check_err(scerr)
  );

  fa_fault_campaign_ctrl #(
    .NUM_SITES(1), .SETTLE(ST2), .DROP(0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .done(done2),
    .A(A2), .B(B2), .Cin(Cin2),
    .fault_enable(fen2), .stuck_val(stk2), .fault_site(fsite2),
    .fault_sum(fsum2), .fault_cout(fcout2),
    .res(rif2),
    .detected_count(dcnt2), .self_check_err(scerr2)
  );

  // sites: 0 = A^B, 1 = A&B, 2 = (A^B)&Cin, 3 = Cin input
  function automatic logic [1:0] fa_mis(
    input logic a, input logic b, input logic c,
    input logic en, input logic sv, input int site
  );
    logic x, g, p, ci, s, co;
    x  = a ^ b;
    g  = a & b;
    ci = c;
    if (en && site == 0) x = sv;
    if (en && site == 1) g = sv;
    if (en && site == 3) ci = sv;
    p = x & ci;
    if (en && site == 2) p = sv;
    s  = x ^ ci;
    co = g | p;
    return {s ^ (a ^ b ^ c), co ^ ((a & b) | (c & (a | b)))};
  endfunction

  always_comb begin
    {fsum, fcout} = fa_mis(A, B, Cin, fen & ~ign, stk, int'(fsite));
    if (force_sc && !fen) fsum = 1'b1;
  end

  always_comb begin
    {fsum2, fcout2} = fa_mis(A2, B2, Cin2, fen2, stk2, int'(fsite2));
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pk(input int site, input int s, input int d, input int v);
    return site * 64 + s * 16 + d * 8 + v;
  endfunction

  task automatic build(input bit ig);
    exp_q.delete();
    for (int f = 0; f < NF; f++) begin
      rec_t r;
      logic [2:0] v3;
      logic [1:0] m;
      r.site = f / 2;
      r.stk  = f % 2;
      r.det  = 0;
      r.vec  = 0;
      r.k    = 8;
      if (!ig) begin
        for (int v = 0; v < 8; v++) begin
          v3 = 3'(v);
          m = fa_mis(v3[2], v3[1], v3[0], 1'b1, 1'(r.stk), r.site);
          if (r.det == 0 && m != 2'b00) begin
            r.det = 1;
            r.vec = v;
            r.k   = (DR != 0) ? v + 1 : 8;
          end
        end
      end
      exp_q.push_back(r);
    end
  endtask

  // rmode: 0 ready high, 1 random ready + stray starts, 2 five-cycle stall
  task automatic run(input bit ig, input bit fc, input int rmode);
    int cyc, exp_cyc, mcnt, stalls, hold;
    rec_t r, a;
    ign = ig;
    force_sc = fc;
    build(ig);
    got_q.delete();
    exp_cyc = 8 * (ST + 1);
    foreach (exp_q[i]) exp_cyc += exp_q[i].k * (ST + 1) + 2;
    mcnt = 0;
    stalls = 0;
    hold = 5;
    rif.res_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    chk("start_busy", busy, 1);
    chk("start_vec", {A, B, Cin}, 0);
    chk("start_fen", fen, 0);
    chk("start_cnt", dcnt, 0);
    chk("start_scerr", scerr, 0);
    while (!done && cyc <= LIM) begin
      if (cyc == ST + 1) chk("sc_pre_sample", scerr, 0);
      if (cyc == ST + 2) chk("sc_after_sample", scerr, fc);
      chk("det_count", dcnt, mcnt);
      a.site = int'(rif.res_site);
      a.stk  = int'(rif.res_stuck);
      a.det  = int'(rif.res_detected);
      a.vec  = int'(rif.res_vector);
      a.k    = 0;
      if (rif.res_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_record", 1, 0);
        end else begin
          r = exp_q[0];
          chk("payload", pk(a.site, a.stk, a.det, a.vec),
              pk(r.site, r.stk, r.det, r.vec));
        end
      end
      case (rmode)
        1: rif.res_ready = ($urandom % 3) != 0;
        2: rif.res_ready = !(rif.res_valid && hold > 0);
        default: rif.res_ready = 1'b1;
      endcase
      if (rif.res_valid && !rif.res_ready) begin
        stalls++;
        if (hold > 0) hold--;
      end
      if (rif.res_valid && rif.res_ready && exp_q.size() > 0) begin
        mcnt += exp_q[0].det;
        got_q.push_back(a);
        void'(exp_q.pop_front());
      end
      start = (rmode == 1) && (($urandom % 16) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("timeout", cyc > LIM, 0);
    chk("campaign_cycles", cyc, exp_cyc + stalls);
    chk("done_not_busy", busy, 0);
    chk("records_left", exp_q.size(), 0);
    chk("final_count", dcnt, mcnt);
    chk("final_scerr", scerr, fc);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("hold_count", dcnt, mcnt);
  endtask

  initial begin
    int n, cyc;
    bit bad;
    rec_t a;
    tbl[0] = '{0, 0, 0, 1, 2};
    tbl[1] = '{1, 0, 1, 1, 0};
    tbl[2] = '{2, 1, 0, 1, 6};
    tbl[3] = '{3, 1, 1, 1, 0};
    tbl[4] = '{4, 2, 0, 1, 3};
    tbl[5] = '{5, 2, 1, 1, 0};
    tbl[6] = '{6, 3, 0, 1, 1};
    tbl[7] = '{7, 3, 1, 1, 0};

    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    ign = 1'b0;
    force_sc = 1'b0;
    rif.res_ready = 1'b0;
    rif2.res_ready = 1'b1;
    #12;
    chk("reset_outputs",
        {busy, done, A, B, Cin, fen, stk, fsite, rif.res_valid,
         rif.res_site, rif.res_stuck, rif.res_detected,
         rif.res_vector, dcnt, scerr}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 1'b0, 0);
    chk("table_records", got_q.size(), NF);
    for (int i = 0; i < NF; i++) begin
      if (tbl[i].idx < got_q.size()) begin
        a = got_q[tbl[i].idx];
        chk("table_rec", pk(a.site, a.stk, a.det, a.vec),
            pk(tbl[i].site, tbl[i].stk, tbl[i].det, tbl[i].vec));
      end
    end

    run(1'b1, 1'b0, 0);
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 1);
    repeat (4) run(1'($urandom % 2), 1'($urandom % 2), 1);

    // asynchronous reset during APPLY of fault 1
    ign = 1'b0;
    force_sc = 1'b0;
    rif.res_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!rif.res_valid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_record", n < LIM, 1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_fen", fen, 1);
    chk("pre_rst_site", {fsite, stk}, 1);
    chk("pre_rst_count", dcnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset",
        {busy, done, A, B, Cin, fen, stk, fsite, rif.res_valid,
         rif.res_site, rif.res_stuck, rif.res_detected,
         rif.res_vector, dcnt, scerr}, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy || rif.res_valid) bad = 1'b1;
    end
    chk("post_reset_quiet", bad, 0);
    run(1'b0, 1'b0, 0);

    // DROP=0, single XOR site, SETTLE=1
    got_q.delete();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc <= LIM) begin
      if (rif2.res_valid) begin
        a.site = int'(rif2.res_site);
        a.stk  = int'(rif2.res_stuck);
        a.det  = int'(rif2.res_detected);
        a.vec  = int'(rif2.res_vector);
        got_q.push_back(a);
      end
      @(negedge clk);
      cyc++;
    end
    chk("nodrop_cycles", cyc, 8 * (ST2 + 1) + 2 * (8 * (ST2 + 1) + 2));
    chk("nodrop_records", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("nodrop_rec0", pk(got_q[0].site, got_q[0].stk, got_q[0].det,
          got_q[0].vec), pk(0, 0, 1, 2));
      chk("nodrop_rec1", pk(got_q[1].site, got_q[1].stk, got_q[1].det,
          got_q[1].vec), pk(0, 1, 1, 0));
    end
    chk("nodrop_count", dcnt2, 2);
    chk("nodrop_scerr", scerr2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_fault_campaign_ctrl.md
# fa_fault_campaign_ctrl

Sequencer for the full-adder fault-detection datapath: runs a complete stuck-at fault campaign against the good/faulty full-adder pair and its Sum/Cout comparators. It first runs a fault-free self-check pass, then injects every (site, stuck value) fault in turn and applies all eight {A,B,Cin} vectors. It samples the comparator outputs and reports one detection record per fault through a valid/ready handshake. It sits between the campaign host and the faulty_full_adder / comparator instances.

## Interface
Parameters:
- NUM_SITES, 4, number of injectable fault nodes in the faulty adder (≥1); SW = max(1, $clog2(NUM_SITES))
- SETTLE, 2, cycles a vector is held before the comparator flags are sampled (≥1)
- DROP, 1, 1 = stop applying vectors to a fault once it is detected; 0 = always apply all 8

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle campaign request, accepted only in IDLE
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse when the campaign completes
- A, B, Cin  out  1 each  vector driven to both adders
- fault_enable  out  1  fault injection enable to the faulty adder
- stuck_val  out  1  stuck-at value to the faulty adder
- fault_site  out  SW  injected node index
- fault_sum, fault_cout  in  1 each  comparator mismatch flags
- res_valid  out  1  detection record available
- res_ready  in  1  host accepts the record
- res_site  out  SW  site of the record
- res_stuck  out  1  stuck value of the record
- res_detected  out  1  fault detected by at least one vector
- res_vector  out  3  first detecting {A,B,Cin}; 0 if undetected
- detected_count  out  $clog2(2*NUM_SITES+1)  detected faults this campaign
- self_check_err  out  1  sticky: a mismatch was seen with fault_enable=0

## Operation
- FSM states: IDLE, APPLY, SAMPLE, REPORT, DONE.
- IDLE + start: clear detected_count and self_check_err; vec=0; enter self-check pass (fault_enable=0); busy=1.
- APPLY: drive {A,B,Cin}=vec and the current fault controls, all registered. Hold for SETTLE cycles.
- SAMPLE (1 cycle): hit = fault_sum | fault_cout.
  - Self-check pass: hit sets self_check_err.
  - Fault pass: the first hit latches res_vector=vec and sets the detected flag.
  - Then, if vec==7, or if DROP=1 and the fault is detected: the fault pass goes to REPORT and the self-check pass goes to the first fault. Otherwise vec+1, back to APPLY.
- Fault order: (site 0, stuck 0), (0,1), (1,0), … (NUM_SITES-1, 1). There are 2·NUM_SITES faults; each starts at vec=0 with fault_enable=1.
- REPORT: res_valid=1 with a stable payload until res_ready.
  - On the handshake, detected_count increments if res_detected.
  - Then advance to the next fault, or to DONE after the last one.
- DONE: done=1 for one cycle, busy=0, fault_enable=0; go to IDLE.
- detected_count and self_check_err hold until the next accepted start.
- The self-check pass produces no record and continues after an error.
- start is ignored outside IDLE.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE.
- The start cycle is t0. At t0+1 the FSM is in APPLY with vec=0, busy=1, and the new vector and fault controls are on the ports.
- Each vector occupies SETTLE+1 cycles. Flags are sampled in the SAMPLE cycle, SETTLE cycles after the vector change.
- Self-check pass: always 8·(SETTLE+1) cycles.
- Each fault: k·(SETTLE+1) cycles, plus REPORT (≥1 cycle) and one transition cycle. k=8 if DROP=0 or the fault is undetected; otherwise k = first detecting vec + 1.
- With res_ready tied high, REPORT lasts exactly 1 cycle. Backpressure stretches only REPORT; the payload must not change while valid && !ready.
- rst_n asserted mid-campaign: all outputs return to 0 immediately (asynchronous), with no record and no done pulse.
- The vector counter wraps only at a fault boundary and never increments past 7.

## Test plan
- NUM_SITES=1, site 0 = XOR node A^B, DROP=1, res_ready=1, start → 2 records:
  - (site0, stuck0, detected=1, vector=3'b010)
  - (site0, stuck1, detected=1, vector=3'b000)
  - detected_count=2, self_check_err=0, one done pulse.
- Faulty adder that ignores injection → every record has detected=0, vector=0; detected_count=0; each fault spends exactly 8·(SETTLE+1) cycles in APPLY/SAMPLE.
- fault_sum forced 1 during the self-check pass → self_check_err=1 at the first SAMPLE; the campaign still completes; the flag clears on the next start.
- res_ready low for 5 cycles in REPORT → res_valid held, payload constant, detected_count increments only on the handshake cycle.
- DROP=0 with the XOR stuck-at-0 fault → all 8 vectors applied; res_vector still 3'b010.
- rst_n pulsed low during APPLY of fault 1 → outputs 0 at once; after release, no done; a new start begins cleanly at the self-check pass; a start pulse while busy has no effect.
